// File: rtl/maxnet_controller_if.sv
// Handshake/strobe bundle between the Maxnet control FSM and its environment.
// master: the controller side (drives strobes and status).
// slave:  the datapath/consumer side (drives start, dp_done, out_ready).
interface maxnet_controller_if #(
  parameter int ITER_W = 8
);
  logic              start;
  logic              dp_done;
  logic              out_ready;
  logic              ldI;
  logic              ldInit;
  logic              ldA;
  logic              ldM;
  logic              ldRes;
  logic              busy;
  logic              out_valid;
  logic [ITER_W-1:0] iter_cnt;
  logic              timeout;

  modport master (
    input  start, dp_done, out_ready,
    output ldI, ldInit, ldA, ldM, ldRes, busy, out_valid, iter_cnt, timeout
  );

  modport slave (
    output start, dp_done, out_ready,
    input  ldI, ldInit, ldA, ldM, ldRes, busy, out_valid, iter_cnt, timeout
  );
endinterface

// File: rtl/maxnet_controller.sv
// Maxnet winner-take-all control FSM.
// Sequences LOAD -> INIT -> (CHECK -> MULT -> ADD -> UPD)* -> OUT and hands the
// datapath max to the consumer with a valid/ready handshake.
// Optional iteration limit: define MAXNET_TIMEOUT_EN to end a run at CHECK once
// iter_cnt >= MAX_ITER (dp_done still has priority). Without it, timeout stays 0.
module maxnet_controller #(
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 100,
  parameter int MUL_CYC  = 1,
  parameter int ADD_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  maxnet_controller_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    INIT  = 3'd2,
    CHECK = 3'd3,
    MULT  = 3'd4,
    ADD   = 3'd5,
    UPD   = 3'd6,
    OUT   = 3'd7
  } state_t;

`ifdef MAXNET_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // Wait counter counts down from (cycles-1) to 0 inside MULT and ADD.
  localparam int WAIT_MAX = (MUL_CYC > ADD_CYC) ? MUL_CYC : ADD_CYC;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] MUL_LAST = WAIT_W'(MUL_CYC - 1);
  localparam logic [WAIT_W-1:0] ADD_LAST = WAIT_W'(ADD_CYC - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              timeout_q, timeout_d;
  logic              ldI_q, ldI_d;
  logic              ldInit_q, ldInit_d;
  logic              ldA_q, ldA_d;
  logic              ldM_q, ldM_d;
  logic              ldRes_q, ldRes_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic              limit_hit;

  // Iteration limit reached; constant 0 when the limit feature is compiled out.
  assign limit_hit = TIMEOUT_EN && (int'(iter_q) >= MAX_ITER);

  // Next-state, counters and Moore outputs decoded from the next state so the
  // strobes come straight out of flops.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    iter_d    = iter_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = LOAD;
          iter_d    = '0;
          timeout_d = 1'b0;
        end
      end
      LOAD:  state_d = INIT;
      INIT:  state_d = CHECK;
      CHECK: begin
        if (bus.dp_done) begin
          state_d = OUT;
        end else if (limit_hit) begin
          state_d   = OUT;
          timeout_d = 1'b1;
        end else begin
          state_d = MULT;
          wait_d  = MUL_LAST;
        end
      end
      MULT: begin
        if (wait_q == '0) begin
          state_d = ADD;
          wait_d  = ADD_LAST;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ADD: begin
        if (wait_q == '0) begin
          state_d = UPD;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      UPD: begin
        // Saturate so a long run never wraps back to a small count.
        if (iter_q != '1) begin
          iter_d = iter_q + 1'b1;
        end
        state_d = CHECK;
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ldI_d       = (state_d == LOAD);
    ldInit_d    = (state_d == INIT);
    ldA_d       = (state_d == INIT) || (state_d == UPD);
    ldM_d       = (state_d == MULT);
    ldRes_d     = (state_d == ADD);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == OUT);
  end

  // State, counters and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      iter_q      <= '0;
      timeout_q   <= 1'b0;
      ldI_q       <= 1'b0;
      ldInit_q    <= 1'b0;
      ldA_q       <= 1'b0;
      ldM_q       <= 1'b0;
      ldRes_q     <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      iter_q      <= iter_d;
      timeout_q   <= timeout_d;
      ldI_q       <= ldI_d;
      ldInit_q    <= ldInit_d;
      ldA_q       <= ldA_d;
      ldM_q       <= ldM_d;
      ldRes_q     <= ldRes_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.ldI       = ldI_q;
  assign bus.ldInit    = ldInit_q;
  assign bus.ldA       = ldA_q;
  assign bus.ldM       = ldM_q;
  assign bus.ldRes     = ldRes_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.iter_cnt  = iter_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Self-checking bench for maxnet_controller: a default-parameter instance and a
// multicycle instance (MUL_CYC=3, ADD_CYC=2, MAX_ITER=3).
module tb_maxnet_controller;
  localparam int W     = 8;
  localparam int M0    = 1;
  localparam int A0    = 1;
  localparam int M1    = 3;
  localparam int A1    = 2;
  localparam int MAXI0 = 100;
  localparam int MAXI1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maxnet_controller_if #(.ITER_W(W)) bus0 ();
  maxnet_controller_if #(.ITER_W(W)) bus1 ();

  maxnet_controller #(.ITER_W(W), .MAX_ITER(MAXI0), .MUL_CYC(M0), .ADD_CYC(A0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  maxnet_controller #(.ITER_W(W), .MAX_ITER(MAXI1), .MUL_CYC(M1), .ADD_CYC(A1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [1:0] start_r, done_r, ready_r;
  assign bus0.start     = start_r[0];
  assign bus0.dp_done   = done_r[0];
  assign bus0.out_ready = ready_r[0];
  assign bus1.start     = start_r[1];
  assign bus1.dp_done   = done_r[1];
  assign bus1.out_ready = ready_r[1];

  // {ldI, ldInit, ldA, ldM, ldRes, busy, out_valid, timeout}
  logic [7:0]   o_vec  [2];
  logic [W-1:0] o_iter [2];
  assign o_vec[0]  = {bus0.ldI, bus0.ldInit, bus0.ldA, bus0.ldM, bus0.ldRes,
                      bus0.busy, bus0.out_valid, bus0.timeout};
  assign o_vec[1]  = {bus1.ldI, bus1.ldInit, bus1.ldA, bus1.ldM, bus1.ldRes,
                      bus1.busy, bus1.out_valid, bus1.timeout};
  assign o_iter[0] = bus0.iter_cnt;
  assign o_iter[1] = bus1.iter_cnt;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    int sel;
    int out_k;
    int iter;
    bit to;
    int n_lda;
    int n_ldm;
    int n_ldres;
    int run_ldm;
  } exp_t;

  exp_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete run on instance sel. iters: MULT/ADD/UPD loops before the run
  // ends. no_done: dp_done never asserted (run must end by limit). hold: cycles
  // out_ready stays low once out_valid is up (also injects stray start pulses).
  task automatic run_case(input int sel, input int iters, input bit no_done,
                          input int hold, input bit exp_to, input int exp_iter);
    int   m, a, per, done_k;
    exp_t e, g;
    int   n_ldi, n_ldinit, n_lda, n_ldm, n_ldres;
    int   first_ldi, first_ldinit, out_seen, gaps, multi, run, maxrun, bad, grp;
    m      = (sel != 0) ? M1 : M0;
    a      = (sel != 0) ? A1 : A0;
    per    = m + a + 2;
    done_k = 3 + iters * per;
    e.sel     = sel;
    e.out_k   = 4 + iters * per;
    e.iter    = exp_iter;
    e.to      = exp_to;
    e.n_lda   = 1 + iters;
    e.n_ldm   = iters * m;
    e.n_ldres = iters * a;
    e.run_ldm = (iters > 0) ? m : 0;
    sb.push_back(e);

    n_ldi = 0; n_ldinit = 0; n_lda = 0; n_ldm = 0; n_ldres = 0;
    first_ldi = -1; first_ldinit = -1; out_seen = -1;
    gaps = 0; multi = 0; run = 0; maxrun = 0;

    start_r[sel] = 1'b1;
    ready_r[sel] = (hold == 0);
    done_r[sel]  = (!no_done && iters == 0);
    for (int k = 1; k <= e.out_k + 40 && out_seen < 0; k++) begin
      step();
      if (o_vec[sel][7]) begin n_ldi++;    if (first_ldi < 0)    first_ldi = k;    end
      if (o_vec[sel][6]) begin n_ldinit++; if (first_ldinit < 0) first_ldinit = k; end
      if (o_vec[sel][5]) n_lda++;
      if (o_vec[sel][4]) begin n_ldm++; run++; if (run > maxrun) maxrun = run; end
      else run = 0;
      if (o_vec[sel][3]) n_ldres++;
      grp = int'(o_vec[sel][7]) + int'(o_vec[sel][6] | o_vec[sel][5])
          + int'(o_vec[sel][4]) + int'(o_vec[sel][3]);
      if (grp > 1) multi++;
      if (o_vec[sel][1]) begin
        out_seen = k;
        start_r[sel] = 1'b0;
      end else begin
        if (!o_vec[sel][2]) gaps++;
        start_r[sel] = (hold > 0) && (k % 3 == 0);
        done_r[sel]  = !no_done && (iters == 0 || k >= done_k || (k == 4 || k == 5));
      end
    end
    done_r[sel] = 1'b0;

    g = sb.pop_front();
    tests++;
    if (out_seen < 0) begin
      failed++;
      $display("[TB] FAIL out_valid_wait sel=%0d: never seen, required cycle %0d", sel, g.out_k);
    end else begin
      $display("[TB] run sel=%0d out_valid at cycle %0d iter_cnt=%0d timeout=%0d",
               sel, out_seen, o_iter[sel], o_vec[sel][0]);
      if (out_seen !== g.out_k) begin
        failed++;
        $display("[TB] FAIL latency sel=%0d: got %0d required %0d", sel, out_seen, g.out_k);
      end
    end
    tests++;
    if (int'(o_iter[sel]) !== g.iter) begin
      failed++;
      $display("[TB] FAIL iter_cnt sel=%0d: got %0d required %0d", sel, o_iter[sel], g.iter);
    end
    tests++;
    if (o_vec[sel][0] !== g.to) begin
      failed++;
      $display("[TB] FAIL timeout sel=%0d: got %0d required %0d", sel, o_vec[sel][0], g.to);
    end
    tests++;
    if (n_ldi !== 1 || first_ldi !== 1 || n_ldinit !== 1 || first_ldinit !== 2) begin
      failed++;
      $display("[TB] FAIL load_init sel=%0d: ldI n=%0d@%0d ldInit n=%0d@%0d required 1@1 1@2",
               sel, n_ldi, first_ldi, n_ldinit, first_ldinit);
    end
    tests++;
    if (n_lda !== g.n_lda || n_ldm !== g.n_ldm || n_ldres !== g.n_ldres || maxrun !== g.run_ldm) begin
      failed++;
      $display("[TB] FAIL strobe_counts sel=%0d: ldA=%0d ldM=%0d ldRes=%0d ldMrun=%0d required %0d %0d %0d %0d",
               sel, n_lda, n_ldm, n_ldres, maxrun, g.n_lda, g.n_ldm, g.n_ldres, g.run_ldm);
    end
    tests++;
    if (multi !== 0 || gaps !== 0) begin
      failed++;
      $display("[TB] FAIL exclusivity sel=%0d: multi-strobe cycles=%0d not-busy cycles=%0d required 0 0",
               sel, multi, gaps);
    end

    // Consumer stalls: result must stay presented with no strobes.
    if (hold > 0) begin
      bad = 0;
      for (int h = 0; h < hold; h++) begin
        step();
        if (o_vec[sel][1] !== 1'b1 || o_vec[sel][7:3] !== 5'b0) bad++;
      end
      tests++;
      if (bad !== 0) begin
        failed++;
        $display("[TB] FAIL out_hold sel=%0d: bad cycles %0d required 0", sel, bad);
      end
      start_r[sel] = 1'b1;  // coincides with the transfer edge: must be ignored
    end
    ready_r[sel] = 1'b1;
    step();
    start_r[sel] = 1'b0;
    tests++;
    if (o_vec[sel][7:1] !== 7'b0 || o_vec[sel][0] !== g.to || int'(o_iter[sel]) !== g.iter) begin
      failed++;
      $display("[TB] FAIL transfer_idle sel=%0d: outputs=%b iter=%0d required 0000000 to=%0d iter=%0d",
               sel, o_vec[sel][7:1], o_iter[sel], g.to, g.iter);
    end
    if (hold > 0) begin
      step();
      tests++;
      if (o_vec[sel][7:1] !== 7'b0) begin
        failed++;
        $display("[TB] FAIL start_at_transfer sel=%0d: outputs=%b required 0000000", sel, o_vec[sel][7:1]);
      end
    end
    step();
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      tests++;
      if (o_vec[s] !== 8'b0 || o_iter[s] !== '0) begin
        failed++;
        $display("[TB] FAIL reset sel=%0d: outputs=%b iter=%0d required 0", s, o_vec[s], o_iter[s]);
      end
    end
    $display("[TB] reset state checked");
  endtask

  task automatic test_single();
    run_case(0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_two_iter();
    run_case(0, 2, 1'b0, 0, 1'b0, 2);
  endtask

  task automatic test_multicycle();
    run_case(1, 1, 1'b0, 0, 1'b0, 1);
  endtask

  task automatic test_out_hold();
    run_case(0, 1, 1'b0, 5, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    run_case(1, 0, 1'b0, 0, 1'b0, 0);
    run_case(1, 2, 1'b0, 0, 1'b0, 2);
  endtask

  // Reset asserted during the second iteration's ADD on the default instance.
  task automatic test_mid_reset();
    start_r[0] = 1'b1;
    done_r[0]  = 1'b0;
    ready_r[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      start_r[0] = 1'b0;
    end
    tests++;
    if (o_vec[0][3] !== 1'b1 || o_iter[0] !== 8'd1) begin
      failed++;
      $display("[TB] FAIL pre_reset_add: ldRes=%0d iter=%0d required 1 1", o_vec[0][3], o_iter[0]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (o_vec[0] !== 8'b0 || o_iter[0] !== '0) begin
      failed++;
      $display("[TB] FAIL mid_reset: outputs=%b iter=%0d required 0", o_vec[0], o_iter[0]);
    end
    $display("[TB] reset during ADD checked");
    step();
    run_case(0, 1, 1'b0, 0, 1'b0, 1);
  endtask

  task automatic test_limit();
`ifdef MAXNET_TIMEOUT_EN
    run_case(1, MAXI1, 1'b1, 0, 1'b1, MAXI1);
    run_case(1, 0, 1'b0, 0, 1'b0, 0);
`else
    run_case(0, 300, 1'b0, 0, 1'b0, 255);
`endif
  endtask

  initial begin
    start_r = '0;
    done_r  = '0;
    ready_r = '1;
    rst     = 1'b1;
    step();
    step();
    step();
    test_reset();
    rst = 1'b0;
    step();
    test_single();
    test_two_iter();
    test_multicycle();
    test_out_hold();
    test_back_to_back();
    test_mid_reset();
    test_limit();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
